obstacle_hit_reader: RTL and testbench
======================================

Name: obstacle_hit_reader

Overview:
- Reads the 30x40 obstacle map produced by the obstacle shift-register bank and reports whether the 4x4 bird overlaps a pipe cell, the ceiling or the floor.
- Sits beside the drawing FSM in the top level. The FSM pulses start once per frame after it moves the bird, then waits for done.
- This is the read side of the map that the obstacle writer fills. It uses the same cell geometry the renderer uses.

Parameters:
- COLS, 40, cells per row (bits per shift register)
- ROWS, 30, number of rows (shift registers)
- ORIGIN_X, 156, screen x of column 0's left pixel; column c starts at ORIGIN_X-4c
- ORIGIN_Y, 0, screen y of row 0's top pixel; row r starts at ORIGIN_Y+4r
- CEIL_Y, 10, ceiling line y
- FLOOR_Y, 110, floor line y

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous reset, active-high despite the name (codebase naming)
- start  in  1  request a check; one-cycle pulse
- bird_x  in  8  bird top-left x, sampled on start
- bird_y  in  8  bird top-left y, sampled on start
- obstacle_data  in  ROWS*COLS  map; bit index = col + row*COLS
- map_shift  in  1  high in the cycle the map shifts (frame tick)
- busy  out  1  check in progress
- done  out  1  one-cycle result strobe
- hit  out  1  result, valid from done until next accepted start
- hit_index  out  11  map index of first hit cell (see Optional Feature)

Behaviour:
- Reset (async, resetn=1) puts state to IDLE and drives busy=0, done=0, hit=0, hit_index=0.
- FSM states are IDLE, BORDER, PROBE0..PROBE3, DONE. The state register and all outputs are registered.
- IDLE/DONE + start: latch bird_x/bird_y, clear hit and hit_index, go to BORDER, busy=1. In any other state start is ignored.
- BORDER:
  - If bird_y <= CEIL_Y or bird_y+3 >= FLOOR_Y (9-bit sum, no wrap): hit=1, hit_index=0, go to DONE.
  - Otherwise go to PROBE0.
- PROBEk probes corner k in this order: 0=(x,y), 1=(x+3,y), 2=(x,y+3), 3=(x+3,y+3).
  - Column: c = (ORIGIN_X+3-px)>>2, computed in 9-bit arithmetic.
  - Row: r = (py-ORIGIN_Y)>>2.
  - The corner is skipped (no hit) if px > ORIGIN_X+3, py < ORIGIN_Y, c >= COLS or r >= ROWS.
  - If the corner is valid and obstacle_data[c+r*COLS]=1: hit=1, hit_index=c+r*COLS, go to DONE.
  - Otherwise go to PROBE(k+1). PROBE3 with no hit goes to DONE with hit=0.
- DONE: done=1 and busy=0 for exactly one cycle. Without start the FSM returns to IDLE; with start it goes to BORDER.
- Latency from the start edge E0:
  - border hit: done after E1
  - corner-k hit: done after E(2+k)
  - no hit: done after E5
- map_shift while in any PROBE state: the next state is PROBE0, so all corners are re-probed against the new map. Latched coordinates are kept and the border result stands.
- map_shift and a hit in the same cycle: map_shift wins, the hit is discarded and PROBE0 follows.
- obstacle_data is read combinationally each PROBE cycle. The caller changes it only on map_shift.
- Reset mid-check: immediate return to IDLE, outputs cleared, and no done is issued.

Optional Feature:
- Macro: OBSTACLE_HIT_INDEX_EN.
- Defined: hit_index reports the first hit cell index as above. A border hit reports 0.
- Undefined: hit_index is a constant 0 and no index register is synthesised. hit/done timing is identical in both builds.

Test Plan:
- Reset asserted mid-PROBE2 -> busy=0, done=0, hit=0 immediately; no done after release.
- bird (20,48), only bit 514 set, start -> done after E2, hit=1, hit_index=514.
- bird (22,48), only bit 513 set -> corners 0 and 2 map to 514 (clear), corner 1 maps to 513; done after E3, hit=1, hit_index=513.
- bird_y=8, then bird_y=107, then bird_y=11 with empty map -> first two: done after E1, hit=1; third: done after E5, hit=0.
- bird (158,48), only bit 0+12*40=480 set -> corners 1 and 3 (px=161) skipped; hit=1 via corner 0, index 480.
- Bird (20,48) on empty map; map_shift pulsed in PROBE1 with bit 514 appearing -> restart at PROBE0, done after E4 measured from start, hit=1; start pulsed while busy -> ignored.

Source files
------------

// File: rtl/obstacle_hit_reader.sv
// obstacle_hit_reader
//   Checks whether the 4x4 bird overlaps a pipe cell in the 30x40 obstacle
//   map, or touches the ceiling or the floor. The caller pulses start once
//   per frame and waits for done.
//
// Ports
//   clk            system clock
//   resetn         asynchronous reset, active-high despite the name
//   start          one-cycle check request, accepted only in IDLE or DONE
//   bird_x/bird_y  bird top-left pixel, latched on an accepted start
//   obstacle_data  map, bit index = col + row*COLS, read combinationally
//   map_shift      map shifts this cycle; any probe in flight restarts
//   busy           check in progress
//   done           one-cycle result strobe
//   hit            result, held from done until the next accepted start
//   hit_index      index of the first hit cell (0 for a border hit)
//
// Build option
//   OBSTACLE_HIT_INDEX_EN  defined: hit_index carries the hit cell index.
//                          undefined: hit_index is tied to 0 and has no register.
//
// state  | meaning
// IDLE   | waiting for start
// BORDER | ceiling/floor test on the latched y
// PROBEk | map lookup for corner k: 0=(x,y) 1=(x+3,y) 2=(x,y+3) 3=(x+3,y+3)
// DONE   | result strobe; start here is accepted directly

module obstacle_hit_reader #(
    parameter int COLS     = 40,
    parameter int ROWS     = 30,
    parameter int ORIGIN_X = 156,
    parameter int ORIGIN_Y = 0,
    parameter int CEIL_Y   = 10,
    parameter int FLOOR_Y  = 110
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [7:0]           bird_x,
    input  logic [7:0]           bird_y,
    input  logic [ROWS*COLS-1:0] obstacle_data,
    input  logic                 map_shift,
    output logic                 busy,
    output logic                 done,
    output logic                 hit,
    output logic [10:0]          hit_index
);

    typedef enum logic [2:0] {
        S_IDLE, S_BORDER, S_PROBE0, S_PROBE1, S_PROBE2, S_PROBE3, S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] bx_q, bx_d;
    logic [7:0] by_q, by_d;
    logic       hit_q, hit_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       off_x, off_y;
    logic [8:0] px, py;
    logic [9:0] dx, dy;
    logic [8:0] c_full, r_full;
    logic       corner_valid;
    logic [10:0] cell_idx;
    logic       probe_hit;
    logic       border_hit;

    // Corner offset selected by the probe state.
    always_comb begin
        off_x = 1'b0;
        off_y = 1'b0;
        case (state_q)
            S_PROBE1: off_x = 1'b1;
            S_PROBE2: off_y = 1'b1;
            S_PROBE3: begin
                off_x = 1'b1;
                off_y = 1'b1;
            end
            default: ;
        endcase
    end

    // Columns run right-to-left from ORIGIN_X, rows top-down from ORIGIN_Y.
    // A negative difference (sign bit of the 10-bit result) means the corner
    // lies outside the map on that side and is skipped.
    assign px = {1'b0, bx_q} + (off_x ? 9'd3 : 9'd0);
    assign py = {1'b0, by_q} + (off_y ? 9'd3 : 9'd0);
    assign dx = 10'(ORIGIN_X + 3) - {1'b0, px};
    assign dy = {1'b0, py} - 10'(ORIGIN_Y);
    assign c_full = dx[8:0] >> 2;
    assign r_full = dy[8:0] >> 2;
    assign corner_valid = !dx[9] && !dy[9] &&
                          (c_full < 9'(COLS)) && (r_full < 9'(ROWS));
    // Truncation is harmless: the index is only used when the corner is valid.
    assign cell_idx  = 11'(c_full) + 11'(r_full) * 11'(COLS);
    assign probe_hit = corner_valid && obstacle_data[cell_idx];

    assign border_hit = ({1'b0, by_q} <= 9'(CEIL_Y)) ||
                        (({1'b0, by_q} + 9'd3) >= 9'(FLOOR_Y));

`ifdef OBSTACLE_HIT_INDEX_EN
    logic [10:0] idx_q, idx_d;
`endif

    always_comb begin
        state_d = state_q;
        bx_d    = bx_q;
        by_d    = by_q;
        hit_d   = hit_q;
`ifdef OBSTACLE_HIT_INDEX_EN
        idx_d   = idx_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    bx_d    = bird_x;
                    by_d    = bird_y;
                    hit_d   = 1'b0;
`ifdef OBSTACLE_HIT_INDEX_EN
                    idx_d   = '0;
`endif
                    state_d = S_BORDER;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BORDER: begin
                if (border_hit) begin
                    hit_d   = 1'b1;
`ifdef OBSTACLE_HIT_INDEX_EN
                    idx_d   = '0;
`endif
                    state_d = S_DONE;
                end else begin
                    state_d = S_PROBE0;
                end
            end
            S_PROBE0, S_PROBE1, S_PROBE2, S_PROBE3: begin
                // A map shift invalidates any lookup done so far.
                if (map_shift) begin
                    state_d = S_PROBE0;
                end else if (probe_hit) begin
                    hit_d   = 1'b1;
`ifdef OBSTACLE_HIT_INDEX_EN
                    idx_d   = cell_idx;
`endif
                    state_d = S_DONE;
                end else begin
                    case (state_q)
                        S_PROBE0: state_d = S_PROBE1;
                        S_PROBE1: state_d = S_PROBE2;
                        S_PROBE2: state_d = S_PROBE3;
                        default:  state_d = S_DONE;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q <= S_IDLE;
            bx_q    <= '0;
            by_q    <= '0;
            hit_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            hit_q   <= hit_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef OBSTACLE_HIT_INDEX_EN
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) idx_q <= '0;
        else        idx_q <= idx_d;
    end
    assign hit_index = idx_q;
`else
    assign hit_index = '0;
`endif

    assign busy = busy_q;
    assign done = done_q;
    assign hit  = hit_q;

endmodule

// File: tb/tb_obstacle_hit_reader.sv
module tb_obstacle_hit_reader;

`ifdef OBSTACLE_HIT_INDEX_EN
    localparam bit IDX_EN = 1'b1;
`else
    localparam bit IDX_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [7:0]    bird_x, bird_y;
    logic [1199:0] obstacle_data;
    logic          map_shift;
    logic          busy, done, hit;
    logic [10:0]   hit_index;

    int n_assert = 0;
    int n_fail   = 0;
    int lat;
    int seen_done;

    obstacle_hit_reader dut (
        .clk           (clk),
        .resetn        (resetn),
        .start         (start),
        .bird_x        (bird_x),
        .bird_y        (bird_y),
        .obstacle_data (obstacle_data),
        .map_shift     (map_shift),
        .busy          (busy),
        .done          (done),
        .hit           (hit),
        .hit_index     (hit_index)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the following posedge is E0.
    task automatic pulse_start(input logic [7:0] x, input logic [7:0] y);
        bird_x = x;
        bird_y = y;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Returns n such that done is first seen after E(n); -1 if none within budget.
    task automatic wait_done(input int base, output int n);
        n = -1;
        for (int i = base + 1; i <= base + 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    function automatic logic [31:0] exp_idx(input int v);
        return IDX_EN ? 32'(v) : 32'd0;
    endfunction

    initial begin
        resetn = 1'b1;
        start = 1'b0;
        bird_x = '0;
        bird_y = '0;
        obstacle_data = '0;
        map_shift = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_hit", 32'(hit), 0);
        chk("rst_idx", 32'(hit_index), 0);
        resetn = 1'b0;
        @(negedge clk);

        // Corner 0 hit on cell 514.
        obstacle_data[514] = 1'b1;
        pulse_start(8'd20, 8'd48);
        chk("a_busy", 32'(busy), 1);
        wait_done(0, lat);
        chk("a_lat", 32'(lat), 2);
        chk("a_hit", 32'(hit), 1);
        chk("a_idx", 32'(hit_index), exp_idx(514));
        chk("a_busy_done", 32'(busy), 0);
        @(negedge clk);
        chk("a_done_1cyc", 32'(done), 0);
        chk("a_hit_hold", 32'(hit), 1);

        // Corner 1 hit on cell 513; corners 0/2 land on clear cell 514.
        obstacle_data = '0;
        obstacle_data[513] = 1'b1;
        pulse_start(8'd22, 8'd48);
        wait_done(0, lat);
        chk("b_lat", 32'(lat), 3);
        chk("b_hit", 32'(hit), 1);
        chk("b_idx", 32'(hit_index), exp_idx(513));

        // Ceiling, floor (back-to-back from DONE), then clear flight.
        obstacle_data = '0;
        @(negedge clk);
        pulse_start(8'd20, 8'd8);
        wait_done(0, lat);
        chk("ceil_lat", 32'(lat), 1);
        chk("ceil_hit", 32'(hit), 1);
        chk("ceil_idx", 32'(hit_index), 0);
        pulse_start(8'd20, 8'd107);
        wait_done(0, lat);
        chk("floor_lat", 32'(lat), 1);
        chk("floor_hit", 32'(hit), 1);
        pulse_start(8'd20, 8'd11);
        chk("clr_hit_on_start", 32'(hit), 0);
        wait_done(0, lat);
        chk("free_lat", 32'(lat), 5);
        chk("free_hit", 32'(hit), 0);

        // Right edge: corners at px=161 are skipped, corner 0 hits cell 480.
        obstacle_data[480] = 1'b1;
        @(negedge clk);
        pulse_start(8'd158, 8'd48);
        wait_done(0, lat);
        chk("edge_lat", 32'(lat), 2);
        chk("edge_hit", 32'(hit), 1);
        chk("edge_idx", 32'(hit_index), exp_idx(480));

        // Fully off the right edge: no corner valid.
        @(negedge clk);
        pulse_start(8'd160, 8'd48);
        wait_done(0, lat);
        chk("off_lat", 32'(lat), 5);
        chk("off_hit", 32'(hit), 0);

        // map_shift during PROBE1 with cell 514 appearing; start while busy ignored.
        obstacle_data = '0;
        @(negedge clk);
        pulse_start(8'd20, 8'd48);
        @(negedge clk);
        @(negedge clk);
        chk("sh_busy", 32'(busy), 1);
        map_shift = 1'b1;
        obstacle_data[514] = 1'b1;
        bird_x = 8'd100;
        bird_y = 8'd5;
        start = 1'b1;
        @(negedge clk);
        map_shift = 1'b0;
        start = 1'b0;
        chk("sh_no_done", 32'(done), 0);
        wait_done(3, lat);
        chk("sh_lat", 32'(lat), 4);
        chk("sh_hit", 32'(hit), 1);
        chk("sh_idx", 32'(hit_index), exp_idx(514));

        // Reset in PROBE2.
        obstacle_data = '0;
        @(negedge clk);
        pulse_start(8'd20, 8'd48);
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 1);
        resetn = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_hit", 32'(hit), 0);
        @(negedge clk);
        resetn = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done = 1;
        end
        chk("no_done_after_rst", 32'(seen_done), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
